// File: rtl/busio.sv
// Bus front-end: one outstanding ext bus transaction serving a fetch port and a data port.
// BUSIO_FETCH_BUFFER_EN keeps the fetch buffer valid across hits; undefined, each hit is consumed once.
module busio (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic        mem_load,
    input  logic        mem_store,
    output logic [31:0] mem_load_data,
    output logic        mem_ready,
    output logic        ext_valid,
    input  logic        ext_ready,
    output logic [31:0] ext_address,
    output logic        ext_write,
    output logic [3:0]  ext_strobe,
    output logic [31:0] ext_write_data,
    input  logic [31:0] ext_read_data
);
    typedef enum logic [1:0] {IDLE, FETCH, MEM} state_t;

    state_t      r_state;
    logic [31:0] r_fb_tag, r_fb_data;
    logic        r_fb_valid;
    logic [31:0] r_mb_addr, r_mb_sdata, r_mb_result;
    logic [1:0]  r_mb_size;
    logic        r_mb_signed, r_mb_load, r_mb_store, r_mb_valid;
    logic        r_ext_valid, r_ext_write;
    logic [31:0] r_ext_address, r_ext_write_data;
    logic [3:0]  r_ext_strobe;

    logic        w_mem_req, w_mem_match, w_fetch_hit, w_misaligned, w_fb_consume;
    logic [3:0]  w_strobe;
    logic [31:0] w_wdata, w_load_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_mem_req   = mem_load | mem_store;
    assign w_mem_match = r_mb_valid && (r_mb_addr == mem_address) && (r_mb_size == mem_size)
                         && (r_mb_signed == mem_signed) && (r_mb_load == mem_load)
                         && (r_mb_store == mem_store) && (r_mb_sdata == mem_store_data);
    assign w_fetch_hit = r_fb_valid && (r_fb_tag == fetch_address);
    assign w_misaligned = (mem_size == 2'd3) || ((mem_size == 2'd1) && mem_address[0])
                          || ((mem_size == 2'd2) && (mem_address[1:0] != 2'b00));

`ifdef BUSIO_FETCH_BUFFER_EN
    assign w_fb_consume = 1'b0;
`else
    assign w_fb_consume = w_fetch_hit;
`endif

    always_comb begin
        w_strobe = 4'b1111;
        w_wdata  = mem_store_data;
        case (mem_size)
            2'd0: begin
                w_strobe = 4'b0001 << mem_address[1:0];
                w_wdata  = {4{mem_store_data[7:0]}};
            end
            2'd1: begin
                w_strobe = 4'b0011 << mem_address[1:0];
                w_wdata  = {2{mem_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the captured request, since the inputs may have moved on.
    always_comb begin
        case (r_mb_addr[1:0])
            2'd0:    w_byte = ext_read_data[7:0];
            2'd1:    w_byte = ext_read_data[15:8];
            2'd2:    w_byte = ext_read_data[23:16];
            default: w_byte = ext_read_data[31:24];
        endcase
        w_half = r_mb_addr[1] ? ext_read_data[31:16] : ext_read_data[15:0];
        case (r_mb_size)
            2'd0:    w_load_ext = {{24{r_mb_signed & w_byte[7]}}, w_byte};
            2'd1:    w_load_ext = {{16{r_mb_signed & w_half[15]}}, w_half};
            default: w_load_ext = ext_read_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_fb_tag         <= '0;
            r_fb_data        <= '0;
            r_fb_valid       <= 1'b0;
            r_mb_addr        <= '0;
            r_mb_sdata       <= '0;
            r_mb_result      <= '0;
            r_mb_size        <= '0;
            r_mb_signed      <= 1'b0;
            r_mb_load        <= 1'b0;
            r_mb_store       <= 1'b0;
            r_mb_valid       <= 1'b0;
            r_ext_valid      <= 1'b0;
            r_ext_write      <= 1'b0;
            r_ext_address    <= '0;
            r_ext_write_data <= '0;
            r_ext_strobe     <= '0;
        end else begin
            if (w_fb_consume)
                r_fb_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mem_req && !w_mem_match) begin
                        r_mb_addr   <= mem_address;
                        r_mb_sdata  <= mem_store_data;
                        r_mb_size   <= mem_size;
                        r_mb_signed <= mem_signed;
                        r_mb_load   <= mem_load;
                        r_mb_store  <= mem_store;
                        if (w_misaligned) begin
                            r_mb_result <= '0;
                            r_mb_valid  <= 1'b1;
                        end else begin
                            r_mb_valid       <= 1'b0;
                            r_ext_valid      <= 1'b1;
                            r_ext_address    <= {mem_address[31:2], 2'b00};
                            r_ext_write      <= mem_store;
                            r_ext_strobe     <= w_strobe;
                            r_ext_write_data <= w_wdata;
                            r_state          <= MEM;
                        end
                    end else if (!w_fetch_hit) begin
                        // Tag is claimed at issue; a moved fetch_address simply mismatches after the fill.
                        r_fb_tag         <= fetch_address;
                        r_fb_valid       <= 1'b0;
                        r_ext_valid      <= 1'b1;
                        r_ext_address    <= {fetch_address[31:2], 2'b00};
                        r_ext_write      <= 1'b0;
                        r_ext_strobe     <= 4'b1111;
                        r_ext_write_data <= '0;
                        r_state          <= FETCH;
                    end
                end
                FETCH: begin
                    if (ext_ready) begin
                        r_fb_data   <= ext_read_data;
                        r_fb_valid  <= 1'b1;
                        r_ext_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                MEM: begin
                    if (ext_ready) begin
                        r_mb_result <= r_ext_write ? 32'd0 : w_load_ext;
                        r_mb_valid  <= 1'b1;
                        r_ext_valid <= 1'b0;
                        r_state     <= IDLE;
                        if (r_ext_write && (r_fb_tag[31:2] == r_ext_address[31:2]))
                            r_fb_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fetch_ready    = w_fetch_hit;
    assign fetch_data     = r_fb_data;
    assign mem_ready      = !w_mem_req || w_mem_match;
    assign mem_load_data  = r_mb_result;
    assign ext_valid      = r_ext_valid;
    assign ext_address    = r_ext_address;
    assign ext_write      = r_ext_write;
    assign ext_strobe     = r_ext_strobe;
    assign ext_write_data = r_ext_write_data;
endmodule

// File: tb/tb_busio.sv
// Testbench for busio (default build): directed scenarios, then random data accesses
// against a word-array memory model with a concurrently running fetch stream.
module tb_busio;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_address, fetch_data;
    logic        fetch_ready;
    logic [31:0] mem_address, mem_store_data, mem_load_data;
    logic [1:0]  mem_size;
    logic        mem_signed, mem_load, mem_store, mem_ready;
    logic        ext_valid, ext_ready, ext_write;
    logic [31:0] ext_address, ext_write_data, ext_read_data;
    logic [3:0]  ext_strobe;

    int total = 0;
    int bad   = 0;
    logic [31:0] mem_m [16];

    always #5 clk = ~clk;

    busio dut (
        .clk(clk), .reset(reset),
        .fetch_address(fetch_address), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
        .mem_address(mem_address), .mem_store_data(mem_store_data), .mem_size(mem_size),
        .mem_signed(mem_signed), .mem_load(mem_load), .mem_store(mem_store),
        .mem_load_data(mem_load_data), .mem_ready(mem_ready),
        .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_address(ext_address),
        .ext_write(ext_write), .ext_strobe(ext_strobe), .ext_write_data(ext_write_data),
        .ext_read_data(ext_read_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        ext_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!ext_valid) return;
            tick();
        end
        chk("wait_idle_timeout", {31'd0, ext_valid}, 32'd0);
    endtask

    function automatic logic [3:0] exp_strobe(input logic [1:0] off, input logic [1:0] size);
        if (size == 2'd0) return 4'(1 << off);
        if (size == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] size);
        if (size == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input logic sgn);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = (w >> (8 * off)) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic mem_access(input logic [31:0] a, input logic [1:0] size, input logic sgn,
                              input logic ld, input logic st, input logic [31:0] d);
        logic        mis, done, saw_data, chk_w;
        logic [31:0] exp_rd, ew;
        logic [3:0]  es;
        mis = (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'b00);
        es  = exp_strobe(a[1:0], size);
        ew  = exp_wdata(d, size);
        exp_rd = exp_load(mem_m[a[5:2]], a[1:0], size, sgn);
        done = 1'b0; saw_data = 1'b0; chk_w = 1'b0;
        mem_address = a; mem_size = size; mem_signed = sgn;
        mem_load = ld; mem_store = st; mem_store_data = d;
        for (int k = 0; k < 60 && !done; k++) begin
            #1;
            if (mem_ready) begin
                done = 1'b1;
            end else begin
                if (ext_valid) begin
                    if (ext_address[5:2] != 4'd15) saw_data = 1'b1;
                    if (ext_write && !chk_w) begin
                        chk_w = 1'b1;
                        chk("rnd_st_addr", ext_address, {a[31:2], 2'b00});
                        chk("rnd_st_strobe", {28'd0, ext_strobe}, {28'd0, es});
                        chk("rnd_st_wdata", ext_write_data, ew);
                    end
                    ext_read_data = mem_m[ext_address[5:2]];
                    ext_ready = 1'($urandom_range(0, 1));
                    if (ext_ready && ext_write)
                        for (int b = 0; b < 4; b++)
                            if (es[b]) mem_m[a[5:2]][8*b +: 8] = ew[8*b +: 8];
                end
                @(posedge clk);
            end
        end
        chk("rnd_ready_timeout", {31'd0, done}, 32'd1);
        if (mis) begin
            chk("rnd_misaligned_no_bus", {31'd0, saw_data}, 32'd0);
            chk("rnd_misaligned_result", mem_load_data, 32'd0);
        end else if (ld && !st) begin
            chk("rnd_load_data", mem_load_data, exp_rd);
        end
        mem_load = 1'b0;
        mem_store = 1'b0;
        #1;
        chk("rnd_idle_ready", {31'd0, mem_ready}, 32'd1);
        tick();
    endtask

    initial begin
        reset = 1'b0; fetch_address = 32'h100;
        mem_address = '0; mem_store_data = '0; mem_size = '0; mem_signed = 1'b0;
        mem_load = 1'b0; mem_store = 1'b0; ext_ready = 1'b1; ext_read_data = 32'h13;
        repeat (3) tick();
        chk("rst_ext_valid", {31'd0, ext_valid}, 32'd0);
        chk("rst_ext_write", {31'd0, ext_write}, 32'd0);
        chk("rst_ext_strobe", {28'd0, ext_strobe}, 32'd0);
        chk("rst_ext_address", ext_address, 32'd0);
        chk("rst_ext_wdata", ext_write_data, 32'd0);
        chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        chk("rst_mem_ready_noreq", {31'd0, mem_ready}, 32'd1);
        mem_load = 1'b1; #1;
        chk("rst_mem_ready_load", {31'd0, mem_ready}, 32'd0);
        mem_load = 1'b0; #1;

        // Basic fetch with zero-wait slave, then consume-and-refetch.
        reset = 1'b1;
        tick();
        chk("f_c1_valid", {31'd0, ext_valid}, 32'd1);
        chk("f_c1_addr", ext_address, 32'h100);
        chk("f_c1_write", {31'd0, ext_write}, 32'd0);
        tick();
        chk("f_c2_ready", {31'd0, fetch_ready}, 32'd1);
        chk("f_c2_data", fetch_data, 32'h13);
        chk("f_c2_valid_low", {31'd0, ext_valid}, 32'd0);
        tick();
        chk("f_c3_consumed", {31'd0, fetch_ready}, 32'd0);
        chk("f_c3_valid_low", {31'd0, ext_valid}, 32'd0);
        tick();
        chk("f_c4_refetch", {31'd0, ext_valid}, 32'd1);
        tick();
        chk("f_c5_ready", {31'd0, fetch_ready}, 32'd1);

        // Tie: data request wins over a new fetch.
        fetch_address = 32'h140; mem_load = 1'b1; mem_address = 32'h200; mem_size = 2'd2;
        ext_read_data = 32'hCAFEF00D; #1;
        chk("tie_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        chk("tie_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();
        chk("tie_mem_first", ext_address, 32'h200);
        chk("tie_mem_read", {31'd0, ext_write}, 32'd0);
        chk("tie_word_strobe", {28'd0, ext_strobe}, 32'hF);
        tick();
        chk("tie_mem_done", {31'd0, mem_ready}, 32'd1);
        chk("tie_mem_data", mem_load_data, 32'hCAFEF00D);
        chk("tie_fetch_wait", {31'd0, fetch_ready}, 32'd0);
        ext_read_data = 32'h11111111;
        tick();
        chk("tie_fetch_issue", ext_address, 32'h140);
        tick();
        chk("tie_fetch_ready2", {31'd0, fetch_ready}, 32'd1);
        chk("tie_fetch_data", fetch_data, 32'h11111111);
        chk("tie_no_reissue", {31'd0, mem_ready}, 32'd1);
        mem_load = 1'b0;

        // Signed / unsigned byte load at 0x203.
        wait_idle();
        mem_load = 1'b1; mem_address = 32'h203; mem_size = 2'd0; mem_signed = 1'b1;
        ext_read_data = 32'h80FFFFFF;
        tick();
        chk("lb_addr", ext_address, 32'h200);
        chk("lb_strobe", {28'd0, ext_strobe}, 32'h8);
        tick();
        chk("lb_ready", {31'd0, mem_ready}, 32'd1);
        chk("lb_signed", mem_load_data, 32'hFFFFFF80);
        mem_signed = 1'b0; #1;
        chk("lbu_tag_miss", {31'd0, mem_ready}, 32'd0);
        tick();
        chk("lbu_issue", {31'd0, ext_valid}, 32'd1);
        tick();
        chk("lbu_unsigned", mem_load_data, 32'h00000080);
        mem_load = 1'b0;

        // Half store invalidates a fetch buffer in the same word.
        wait_idle();
        fetch_address = 32'h100; ext_read_data = 32'h13;
        for (int k = 0; k < 20; k++) begin
            if (fetch_ready) break;
            tick();
        end
        chk("sh_fill_fb", {31'd0, fetch_ready}, 32'd1);
        fetch_address = 32'h104; mem_store = 1'b1; mem_address = 32'h102; mem_size = 2'd1;
        mem_store_data = 32'h1234ABCD;
        tick();
        chk("sh_write", {31'd0, ext_write}, 32'd1);
        chk("sh_addr", ext_address, 32'h100);
        chk("sh_strobe", {28'd0, ext_strobe}, 32'hC);
        chk("sh_wdata", ext_write_data, 32'hABCDABCD);
        tick();
        chk("sh_ready", {31'd0, mem_ready}, 32'd1);
        fetch_address = 32'h100; #1;
        chk("sh_fb_invalidated", {31'd0, fetch_ready}, 32'd0);
        mem_store = 1'b0;

        // Misaligned word load.
        wait_idle();
        mem_load = 1'b1; mem_address = 32'h101; mem_size = 2'd2; mem_signed = 1'b0;
        tick();
        chk("mis_ready", {31'd0, mem_ready}, 32'd1);
        chk("mis_data", mem_load_data, 32'd0);
        chk("mis_no_bus", {31'd0, ext_valid}, 32'd0);
        mem_load = 1'b0;

        // Reset in the middle of a stalled transaction.
        wait_idle();
        ext_ready = 1'b0; mem_load = 1'b1; mem_address = 32'h200; mem_size = 2'd2;
        tick();
        chk("rm_c1_valid", {31'd0, ext_valid}, 32'd1);
        tick();
        chk("rm_c2_held", ext_address, 32'h200);
        tick();
        reset = 1'b0; #1;
        chk("rm_valid_drop", {31'd0, ext_valid}, 32'd0);
        chk("rm_addr_clear", ext_address, 32'd0);
        chk("rm_no_fill", {31'd0, mem_ready}, 32'd0);
        chk("rm_no_fetch", {31'd0, fetch_ready}, 32'd0);
        tick(); tick();
        reset = 1'b1; #1;
        chk("rm_after_rst", {31'd0, mem_ready}, 32'd0);
        ext_ready = 1'b1; ext_read_data = 32'h55;
        tick();
        chk("rm_reissue", ext_address, 32'h200);
        tick();
        chk("rm_done", mem_load_data, 32'h55);
        mem_load = 1'b0;

        // Random data accesses against the memory model.
        for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
        fetch_address = 32'h3C;
        tick(); tick();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 2));
            mem_access(32'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), op != 2'd1, op != 2'd0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/busio.md
BUSIO -- requirements
Module: busio

Interface
REQ-001 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_address  in  32  instruction fetch address.
- fetch_data  out  32  fetched instruction word.
- fetch_ready  out  1  fetch_data valid for the current fetch_address.
- mem_address  in  32  data access byte address.
- mem_store_data  in  32  store data, right-aligned.
- mem_size  in  2  access size: 0 byte, 1 half, 2 word.
- mem_signed  in  1  sign-extend load.
- mem_load, mem_store  in  1 each  request qualifiers.
- mem_load_data  out  32  aligned, extended load result.
- mem_ready  out  1  data access complete, or no data access requested.
- ext_valid  out  1  bus request.
- ext_ready  in  1  slave accept/complete.
- ext_address  out  32  word-aligned address, bits[1:0]=0.
- ext_write  out  1  write when 1, read when 0.
- ext_strobe  out  4  byte enables.
- ext_write_data  out  32  lane-replicated store data.
- ext_read_data  in  32  read data, valid when ext_valid&&ext_ready&&!ext_write.

Function
REQ-002 FSM states SHALL be IDLE, FETCH, MEM, with one bus transaction outstanding at most.
REQ-003 In IDLE, a pending data request SHALL enter MEM; otherwise a pending fetch SHALL enter FETCH. Data access wins on a tie.
- Pending data request: mem_load|mem_store with no tag-matching mem buffer.
- Pending fetch: no matching fetch buffer.
REQ-004 ext_valid, ext_address, ext_write, ext_strobe and ext_write_data SHALL be registered and held stable from the state entry until ext_valid&&ext_ready. On that handshake the FSM SHALL return to IDLE.
REQ-005 Fetch buffer SHALL hold address tag, data and valid. fetch_ready = valid && tag==fetch_address, and fetch_data = buffer data.
REQ-006 Mem buffer SHALL hold tag {address, size, signed, load, store, store_data}, result and valid.
- mem_ready = !(mem_load|mem_store) || (valid && tag match).
- A matching identical repeat request SHALL NOT reissue a bus transaction.
REQ-007 Strobes: byte = 1<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data SHALL be replicated: byte into all 4 lanes, half into both halves.
REQ-008 Load data: the selected byte or half SHALL be shifted to bit 0. It SHALL be zero-extended, or sign-extended when mem_signed.
REQ-009 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0, or size 3):
- SHALL issue no bus transaction.
- Mem buffer SHALL be filled from IDLE in one cycle with result 0.
REQ-010 Latency with a zero-wait slave:
- Request seen in IDLE at cycle N.
- ext_valid high at cycle N+1.
- Handshake at N+1.
- Buffer valid and ready high at N+2.
REQ-011 A completed store whose word address equals the fetch buffer word address SHALL clear the fetch buffer valid.
REQ-012 A fetch_address change during FETCH SHALL NOT abort the transaction. The fill completes, then mismatches, and a new fetch follows.
REQ-013 mem_load&&mem_store together SHALL be treated as a store.

Reset
REQ-014 While reset is low, state SHALL be IDLE and both buffer valids 0.
- ext_valid, ext_write, ext_strobe SHALL be 0; ext_address and ext_write_data 0.
- fetch_ready SHALL be 0; mem_ready SHALL follow REQ-006 with valid=0.
REQ-015 Reset asserted mid-transaction SHALL drop ext_valid immediately and discard the pending response.

Configuration
REQ-016 Macro BUSIO_FETCH_BUFFER_EN:
- Defined: the fetch buffer persists until overwritten or invalidated per REQ-011.
- Undefined: fetch buffer valid SHALL clear in the cycle after any cycle in which fetch_ready was 1. A held fetch_address then refetches.

Verification
REQ-017 Zero-wait slave, fetch_address=0x100, ext_read_data=0x00000013 -> ext_valid at cycle 1, fetch_ready=1 with fetch_data=0x00000013 at cycle 2.
REQ-018 Fetch and mem_load both pending in IDLE -> MEM issued first. fetch_ready stays 0 until a following FETCH completes.
REQ-019 mem_load byte signed, address 0x203, ext_read_data=0x80FFFFFF -> ext_address=0x200, ext_strobe=4'b1000, mem_load_data=0xFFFFFF80.
REQ-020 mem_store half, address 0x102, data 0x1234ABCD -> ext_strobe=4'b1100, ext_write_data=0xABCDABCD. A fetch buffer tagged 0x100 is invalidated.
REQ-021 mem_load word at 0x101 -> no ext_valid, mem_ready=1 next cycle, mem_load_data=0.
REQ-022 ext_ready held low 5 cycles with reset pulsed low at cycle 3 -> ext_valid=0 immediately, FSM IDLE, no buffer filled.
